// File: rtl/vga_dither_out.sv
// Board video output stage: reduces IN_BITS to OUT_BITS per colour with optional 4x4
// ordered or frame-rotated dither; sync and blank travel the same 2-stage ce_pix pipe.

module vga_dither_lane #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 6
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic [IN_BITS-1:0]  pix_in,
  input  logic [IN_BITS-1:0]  thr_s1,
  input  logic                blank_s1,
  output logic [OUT_BITS-1:0] pix_out
);
  localparam int D = IN_BITS - OUT_BITS;

  logic [IN_BITS-1:0]  pix_s1_q, pix_s1_d;
  logic [OUT_BITS-1:0] out_q, out_d;
  logic [IN_BITS:0]    sum;

  always_comb begin
    pix_s1_d = ce_pix ? pix_in : pix_s1_q;
    sum      = {1'b0, pix_s1_q} + {1'b0, thr_s1};
    out_d    = out_q;
    if (ce_pix) begin
      // carry out means the threshold pushed past full scale: clamp, never wrap
      if (blank_s1)          out_d = '0;
      else if (sum[IN_BITS]) out_d = '1;
      else                   out_d = sum[IN_BITS-1:D];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pix_s1_q <= '0;
      out_q    <= '0;
    end else begin
      pix_s1_q <= pix_s1_d;
      out_q    <= out_d;
    end
  end

  assign pix_out = out_q;
endmodule

module vga_dither_out #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 6,
  parameter int DITHER_MODE = 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic                dith_en,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                hblank,
  input  logic                vblank,
  output logic [OUT_BITS-1:0] VGA_R,
  output logic [OUT_BITS-1:0] VGA_G,
  output logic [OUT_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                de_out
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;
  localparam int D         = IN_BITS - OUT_BITS;
  localparam bit TEMPORAL  = (DITHER_MODE == 2);

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  sync_t [STAGES:1]   sync_pipe_q, sync_pipe_d;
  logic  [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic  [1:0]        x_q, x_d, y_q, y_d, frame_q, frame_d;
  logic               hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [IN_BITS-1:0] thr_q, thr_d, thr_raw;
  logic [1:0]         row, col;
  logic [3:0]         bayer_v;
  logic               hs_rise, vs_rise, dith_on, blank_s1;

  function automatic logic [3:0] bayer(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'd0;   4'h1: return 4'd8;   4'h2: return 4'd2;   4'h3: return 4'd10;
      4'h4: return 4'd12;  4'h5: return 4'd4;   4'h6: return 4'd14;  4'h7: return 4'd6;
      4'h8: return 4'd3;   4'h9: return 4'd11;  4'hA: return 4'd1;   4'hB: return 4'd9;
      4'hC: return 4'd15;  4'hD: return 4'd7;   4'hE: return 4'd13;  default: return 4'd5;
    endcase
  endfunction

  assign hs_rise = hs_in & ~hs_prev_q;
  assign vs_rise = vs_in & ~vs_prev_q;
  assign dith_on = dith_en && (DITHER_MODE != 0) && (D != 0);

  // temporal mode shifts the tile origin each frame so the pattern averages out
  assign col     = TEMPORAL ? (x_q ^ {1'b0, frame_q[0]}) : x_q;
  assign row     = TEMPORAL ? (y_q ^ {1'b0, frame_q[1]}) : y_q;
  assign bayer_v = bayer(row, col);

  generate
    if (D >= 4) begin : g_thr_shl
      assign thr_raw = IN_BITS'(bayer_v) << (D - 4);
    end else begin : g_thr_shr
      assign thr_raw = IN_BITS'(bayer_v >> (4 - D));
    end
  endgenerate

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_d     = frame_q;
    hs_prev_d   = hs_prev_q;
    vs_prev_d   = vs_prev_q;
    thr_d       = thr_q;
    sync_pipe_d = sync_pipe_q;
    vld_pipe_d  = vld_pipe_q;
    if (ce_pix) begin
      hs_prev_d = hs_in;
      vs_prev_d = vs_in;
      x_d       = hs_rise ? 2'd0 : x_q + 2'd1;
      if (vs_rise)      y_d = 2'd0;
      else if (hs_rise) y_d = y_q + 2'd1;
      if (TEMPORAL && vs_rise) frame_d = frame_q + 2'd1;
      thr_d = dith_on ? thr_raw : '0;
      for (int s = STAGES; s > 1; s--) begin
        sync_pipe_d[s] = sync_pipe_q[s-1];
        vld_pipe_d[s]  = vld_pipe_q[s-1];
      end
      sync_pipe_d[1].hs = hs_in;
      sync_pipe_d[1].vs = vs_in;
      vld_pipe_d[1]     = ~(hblank | vblank);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_q     <= '0;
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      thr_q       <= '0;
      sync_pipe_q <= '1;
      vld_pipe_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_q     <= frame_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      thr_q       <= thr_d;
      sync_pipe_q <= sync_pipe_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  logic [NUM_LANES-1:0][IN_BITS-1:0]  lane_in;
  logic [NUM_LANES-1:0][OUT_BITS-1:0] lane_out;

  assign lane_in  = {b_in, g_in, r_in};
  assign blank_s1 = ~vld_pipe_q[1];

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      vga_dither_lane #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .pix_in   (lane_in[l]),
        .thr_s1   (thr_q),
        .blank_s1 (blank_s1),
        .pix_out  (lane_out[l])
      );
    end
  endgenerate

  assign VGA_R  = lane_out[0];
  assign VGA_G  = lane_out[1];
  assign VGA_B  = lane_out[2];
  assign VGA_HS = sync_pipe_q[STAGES].hs;
  assign VGA_VS = sync_pipe_q[STAGES].vs;
  assign de_out = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_vga_dither_out.sv
// Directed bench for vga_dither_out: truncate, Bayer, temporal and 8->8 pass-through
// instances share one stimulus stream; each vector is checked two ce_pix later.
module tb_vga_dither_out;
  logic       clk = 1'b0;
  logic       reset, ce_pix, dith_en, hs_in, vs_in, hblank, vblank;
  logic [7:0] r_in, g_in, b_in;
  logic [5:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic [7:0] rp, gp, bp;
  logic       hs0, vs0, de0, hs1, vs1, de1, hs2, vs2, de2, hsp, vsp, dep;
  int         n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  vga_dither_out #(.IN_BITS(8), .OUT_BITS(6), .DITHER_MODE(0)) u_m0 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .dith_en(dith_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .VGA_HS(hs0), .VGA_VS(vs0), .de_out(de0));
  vga_dither_out #(.IN_BITS(8), .OUT_BITS(6), .DITHER_MODE(1)) u_m1 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .dith_en(dith_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .de_out(de1));
  vga_dither_out #(.IN_BITS(8), .OUT_BITS(6), .DITHER_MODE(2)) u_m2 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .dith_en(dith_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
    .VGA_HS(hs2), .VGA_VS(vs2), .de_out(de2));
  vga_dither_out #(.IN_BITS(8), .OUT_BITS(8), .DITHER_MODE(1)) u_pt (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .dith_en(dith_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(rp), .VGA_G(gp), .VGA_B(bp),
    .VGA_HS(hsp), .VGA_VS(vsp), .de_out(dep));

  typedef struct {
    logic [7:0] r;
    logic       hs, vs, hb, vb, dith;
    logic [5:0] e0, e1, e2;   // expected red: truncate, Bayer, temporal
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic dith, input logic hs, input logic vs,
                              input logic hb, input logic vb,
                              input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2);
    vec_t v;
    v.r = r; v.dith = dith; v.hs = hs; v.vs = vs; v.hb = hb; v.vb = vb;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic add_px(input logic [7:0] r, input logic dith, input logic hs, input logic vs,
                        input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2);
    tbl.push_back(mk(r, dith, hs, vs, 1'b0, 1'b0, e0, e1, e2));
  endtask

  task automatic add_blk(input logic hs, input logic vs, input logic hb, input logic vb);
    tbl.push_back(mk(8'hFF, 1'b1, hs, vs, hb, vb, 6'h00, 6'h00, 6'h00));
  endtask

  // one pixel: ce_pix high for one clk, low for the next
  task automatic apply(input vec_t v);
    @(negedge clk);
    r_in = v.r; g_in = 8'hFF; b_in = 8'h00;
    hs_in = v.hs; vs_in = v.vs; hblank = v.hb; vblank = v.vb; dith_en = v.dith;
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic de;
    de = !(v.hb || v.vb);
    chk($sformatf("v%0d m0_r", i), r0, v.e0);
    chk($sformatf("v%0d m1_r", i), r1, v.e1);
    chk($sformatf("v%0d m2_r", i), r2, v.e2);
    chk($sformatf("v%0d pt_r", i), rp, de ? v.r : 8'h00);
    chk($sformatf("v%0d m0_g", i), g0, de ? 6'h3F : 6'h00);
    chk($sformatf("v%0d m1_g", i), g1, de ? 6'h3F : 6'h00);
    chk($sformatf("v%0d m2_g", i), g2, de ? 6'h3F : 6'h00);
    chk($sformatf("v%0d pt_g", i), gp, de ? 8'hFF : 8'h00);
    chk($sformatf("v%0d b_all", i), {b0, b1, b2, bp}, 0);
    chk($sformatf("v%0d de", i), {de0, de1, de2, dep}, de ? 4'hF : 4'h0);
    chk($sformatf("v%0d hs", i), {hs0, hs1, hs2, hsp}, v.hs ? 4'hF : 4'h0);
    chk($sformatf("v%0d vs", i), {vs0, vs1, vs2, vsp}, v.vs ? 4'hF : 4'h0);
  endtask

  task automatic run_table();
    vec_t f;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (i > 0) check_vec(i - 1, tbl[i-1]);
    end
    f = tbl[tbl.size()-1];
    f.hb = 1'b1;
    apply(f);
    check_vec(tbl.size() - 1, tbl[tbl.size()-1]);
  endtask

  initial begin
    logic [5:0] e1, e2;
    reset = 1'b1; ce_pix = 1'b1; dith_en = 1'b1;
    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    hs_in = 1'b0; vs_in = 1'b0; hblank = 1'b0; vblank = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rgb", {r1, g1, b1}, 0);
    chk("rst_pt_r", rp, 0);
    chk("rst_de", {de0, de1, de2}, 0);
    chk("rst_sync", {hs0, vs0, hs1, vs1, hs2, vs2}, 6'h3F);
    ce_pix = 1'b0; r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;

    // frame 0 row 0, then a tile of 0x81, a tile of 0xFE, a frame-2 row, vblank + dual rise
    add_px(8'h82, 1, 0, 0, 6'h20, 6'h20, 6'h20);
    add_px(8'hFF, 1, 0, 0, 6'h3F, 6'h3F, 6'h3F);
    add_px(8'h83, 1, 0, 0, 6'h20, 6'h20, 6'h20);
    add_blk(0, 0, 1, 0);
    add_blk(1, 1, 1, 0);
    for (int y = 0; y < 4; y++) begin
      if (y > 0) begin add_blk(0, 1, 1, 0); add_blk(1, 1, 1, 0); end
      for (int x = 0; x < 4; x++) begin
        e1 = (y[0] && !x[0]) ? 6'h21 : 6'h20;
        e2 = (y[0] &&  x[0]) ? 6'h21 : 6'h20;
        add_px(8'h81, 1, 1, 1, 6'h20, e1, e2);
      end
    end
    add_blk(0, 0, 1, 0);
    add_blk(1, 1, 1, 0);
    for (int y = 0; y < 4; y++) begin
      if (y > 0) begin add_blk(0, 1, 1, 0); add_blk(1, 1, 1, 0); end
      for (int x = 0; x < 4; x++) add_px(8'hFE, 1, 1, 1, 6'h3F, 6'h3F, 6'h3F);
    end
    add_blk(0, 1, 1, 0);
    add_blk(1, 1, 1, 0);
    for (int x = 0; x < 4; x++) add_px(8'h81, 1, 1, 1, 6'h20, 6'h20, x[0] ? 6'h20 : 6'h21);
    add_blk(0, 0, 0, 1);
    add_blk(0, 0, 0, 1);
    add_blk(1, 1, 0, 1);
    add_px(8'h83, 1, 1, 1, 6'h20, 6'h20, 6'h21);
    add_px(8'h83, 1, 1, 1, 6'h20, 6'h21, 6'h21);
    run_table();

    // latency with ce_pix every 2nd clk, and hold while ce_pix is low
    apply(mk(8'hFF, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("lat1_r", r0, 6'h00);
    chk("lat1_hs", hs0, 1'b1);
    r_in = 8'h00; hs_in = 1'b1; hblank = 1'b1;
    @(negedge clk);
    chk("lat1_hold_r", r0, 6'h00);
    apply(mk(8'h83, 1, 1, 0, 0, 0, 0, 0, 0));
    chk("lat2_r", r0, 6'h3F);
    chk("lat2_hs", hs0, 1'b0);
    chk("lat2_de", de0, 1'b1);
    apply(mk(8'h00, 1, 1, 0, 1, 0, 0, 0, 0));
    chk("lat3_r", r0, 6'h20);
    r_in = 8'hFF; hblank = 1'b0; vs_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_r", r0, 6'h20);
    chk("hold_vs", vs0, 1'b0);

    // asynchronous reset mid-line
    apply(mk(8'hFF, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(8'hFF, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("pre_rst_r", r1, 6'h3F);
    #2 reset = 1'b1;
    #1;
    chk("midrst_r", {r0, r1, r2}, 0);
    chk("midrst_de", {de0, de1, de2}, 0);
    chk("midrst_sync", {hs1, vs1, hs2, vs2}, 4'hF);
    @(negedge clk);
    reset = 1'b0;

    // counters restart at 0; dith_en=0 falls back to truncation from that pixel on
    tbl.delete();
    add_px(8'h83, 1, 0, 0, 6'h20, 6'h20, 6'h20);
    add_px(8'h83, 1, 0, 0, 6'h20, 6'h21, 6'h21);
    add_px(8'h83, 0, 0, 0, 6'h20, 6'h20, 6'h20);
    add_px(8'h83, 0, 0, 0, 6'h20, 6'h20, 6'h20);
    add_px(8'h83, 1, 0, 0, 6'h20, 6'h20, 6'h20);
    add_px(8'h83, 1, 0, 0, 6'h20, 6'h21, 6'h21);
    add_px(8'hFF, 0, 0, 0, 6'h3F, 6'h3F, 6'h3F);
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
